sha3_multi_scanner_dispatcher: RTL

SHA3_MULTI_SCANNER_DISPATCHER -- requirements
Module: sha3_multi_scanner_dispatcher

---
 rtl/sha3_multi_scanner_dispatcher.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/sha3_multi_scanner_dispatcher.sv
// Job dispatcher for a bank of SHA3 nonce-scanner lanes: splits one block template
// into per-lane nonce ranges, collects the first winning lane, and counts work done.
module sha3_multi_scanner_dispatcher #(
    parameter int          LANES           = 4,
    parameter int          PROPER          = 1,
    parameter int          NONCE_INDEX     = ((PROPER != 0) ? 20 : 24) - 1,
    parameter logic [31:0] LANE_SCAN_COUNT = 32'h0100_0000,
    localparam int         INPUT_ELEMENTS  = (PROPER != 0) ? 20 : 24
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         start,
    input  logic [INPUT_ELEMENTS-1:0][31:0]              blobby,
    input  logic [63:0]                                  threshold,
    output logic                                         idle,
    output logic                                         found,
    output logic                                         exhausted,
    output logic [24:0][63:0]                            hash,
    output logic [31:0]                                  nonce,
    output logic [47:0]                                  hash_count,
    output logic [31:0]                                  scan_count,
    output logic [LANES-1:0]                             lane_start,
    output logic [LANES-1:0]                             lane_stop,
    output logic [LANES-1:0][INPUT_ELEMENTS-1:0][31:0]   lane_blobby,
    output logic [63:0]                                  lane_threshold,
    input  logic [LANES-1:0]                             lane_idle,
    input  logic [LANES-1:0]                             lane_found,
    input  logic [LANES-1:0]                             lane_evaluating,
    input  logic [LANES-1:0][24:0][63:0]                 lane_hash,
    input  logic [LANES-1:0][31:0]                       lane_nonce
);

    localparam int          IW         = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [63:0] SCAN_TOTAL = 64'(LANES) * 64'(LANE_SCAN_COUNT);
    localparam logic [31:0] SCAN_SAT   = (SCAN_TOTAL > 64'h0000_0000_FFFF_FFFF) ?
                                         32'hFFFF_FFFF : SCAN_TOTAL[31:0];

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_DRAIN} state_t;

    function automatic logic [3:0] popcount(input logic [LANES-1:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < LANES; i++) begin
            c = c + {3'd0, v[i]};
        end
        return c;
    endfunction

    // Descending scan so the lowest asserting index is the one left standing.
    function automatic logic [IW-1:0] lowest_set(input logic [LANES-1:0] v);
        logic [IW-1:0] idx;
        idx = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IW'(i);
            end
        end
        return idx;
    endfunction

    state_t                                     state_q, state_d;
    logic                                       first_run_q, first_run_d;
    logic                                       found_q, found_d;
    logic                                       exhausted_q, exhausted_d;
    logic [24:0][63:0]                          hash_q, hash_d;
    logic [31:0]                                nonce_q, nonce_d;
    logic [47:0]                                hash_count_q, hash_count_d;
    logic [LANES-1:0]                           lane_start_q, lane_start_d;
    logic [LANES-1:0]                           lane_stop_q, lane_stop_d;
    logic [LANES-1:0][INPUT_ELEMENTS-1:0][31:0] lane_blobby_q, lane_blobby_d;
    logic [63:0]                                threshold_q, threshold_d;

    logic [48:0]   hc_sum_s;
    logic [47:0]   hc_inc_s;
    logic [IW-1:0] win_idx_s;
    logic          any_found_s;
    logic          all_idle_s;

    // Next-state and next-output computation for the dispatcher.
    always_comb begin
        state_d        = state_q;
        first_run_d    = first_run_q;
        found_d        = found_q;
        exhausted_d    = exhausted_q;
        hash_d         = hash_q;
        nonce_d        = nonce_q;
        hash_count_d   = hash_count_q;
        lane_start_d   = '0;
        lane_stop_d    = lane_stop_q;
        lane_blobby_d  = lane_blobby_q;
        threshold_d    = threshold;

        any_found_s = |lane_found;
        all_idle_s  = &lane_idle;
        win_idx_s   = lowest_set(lane_found);
        hc_sum_s    = {1'b0, hash_count_q} + {45'd0, popcount(lane_evaluating)};
        hc_inc_s    = hc_sum_s[48] ? 48'hFFFF_FFFF_FFFF : hc_sum_s[47:0];

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_LAUNCH;
                    found_d      = 1'b0;
                    exhausted_d  = 1'b0;
                    hash_count_d = 48'd0;
                    lane_start_d = '1;
                    for (int i = 0; i < LANES; i++) begin
                        lane_blobby_d[i]              = blobby;
                        lane_blobby_d[i][NONCE_INDEX] = blobby[NONCE_INDEX] + 32'(i) * LANE_SCAN_COUNT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LAUNCH: begin
                state_d      = S_RUN;
                first_run_d  = 1'b1;
                hash_count_d = hc_inc_s;
            end
            S_RUN: begin
                hash_count_d = hc_inc_s;
                first_run_d  = 1'b0;
                if (any_found_s) begin
                    state_d     = S_DRAIN;
                    found_d     = 1'b1;
                    hash_d      = lane_hash[win_idx_s];
                    nonce_d     = lane_nonce[win_idx_s];
                    lane_stop_d = '1;
                end else if (!first_run_q && all_idle_s) begin
                    state_d     = S_IDLE;
                    exhausted_d = 1'b1;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                hash_count_d = hc_inc_s;
                if (all_idle_s) begin
                    state_d     = S_IDLE;
                    lane_stop_d = '0;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d     = S_IDLE;
                lane_stop_d = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            first_run_q   <= 1'b0;
            found_q       <= 1'b0;
            exhausted_q   <= 1'b0;
            hash_q        <= '0;
            nonce_q       <= 32'd0;
            hash_count_q  <= 48'd0;
            lane_start_q  <= '0;
            lane_stop_q   <= '0;
            lane_blobby_q <= '0;
            threshold_q   <= 64'd0;
        end else begin
            state_q       <= state_d;
            first_run_q   <= first_run_d;
            found_q       <= found_d;
            exhausted_q   <= exhausted_d;
            hash_q        <= hash_d;
            nonce_q       <= nonce_d;
            hash_count_q  <= hash_count_d;
            lane_start_q  <= lane_start_d;
            lane_stop_q   <= lane_stop_d;
            lane_blobby_q <= lane_blobby_d;
            threshold_q   <= threshold_d;
        end
    end

    assign idle           = (state_q == S_IDLE);
    assign found          = found_q;
    assign exhausted      = exhausted_q;
    assign hash           = hash_q;
    assign nonce          = nonce_q;
    assign hash_count     = hash_count_q;
    assign scan_count     = SCAN_SAT;
    assign lane_start     = lane_start_q;
    assign lane_stop      = lane_stop_q;
    assign lane_blobby    = lane_blobby_q;
    assign lane_threshold = threshold_q;

endmodule
